// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the FIFO write-side packer: FSM states, default sizes,
// and the byte-count field width helper.
package fifo_wr_pkg;

    localparam int DEF_DW     = 8;
    localparam int DEF_NBYTES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Width of a field able to hold 0..nbytes inclusive
    function automatic int calc_lw(input int nbytes);
        return $clog2(nbytes) + 1;
    endfunction

endpackage

// File: rtl/packer_hold_reg.sv
// One-entry skid register for a pending word and its length; a full entry
// back-pressures the upstream producer through o_ready.
module packer_hold_reg
    import fifo_wr_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int NBYTES = DEF_NBYTES,
    parameter int LW     = calc_lw(NBYTES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic [NBYTES*DW-1:0] i_data,
    input  logic [LW-1:0]        i_nbytes,
    output logic                 o_valid,
    output logic [NBYTES*DW-1:0] o_data,
    output logic [LW-1:0]        o_nbytes,
    output logic                 o_ready
);

    logic                 valid_reg;
    logic [NBYTES*DW-1:0] data_reg;
    logic [LW-1:0]        nbytes_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_reg  <= 1'b0;
            data_reg   <= '0;
            nbytes_reg <= '0;
        end else if (i_load) begin
            valid_reg  <= 1'b1;
            data_reg   <= i_data;
            nbytes_reg <= i_nbytes;
        end else if (i_clear) begin
            valid_reg  <= 1'b0;
        end
    end

    assign o_valid  = valid_reg;
    assign o_data   = data_reg;
    assign o_nbytes = nbytes_reg;
    assign o_ready  = !valid_reg;

endmodule

// File: rtl/fifo_wr_packer.sv
// Serialises multi-byte words into single-byte FIFO writes, stalling on full.
// Define PACKER_MSB_FIRST_EN to emit the highest valid byte first.
module fifo_wr_packer
    import fifo_wr_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int NBYTES = DEF_NBYTES,
    parameter int LW     = calc_lw(NBYTES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NBYTES*DW-1:0] i_data,
    input  logic [LW-1:0]        i_nbytes,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_wfull,
    output logic                 o_winc,
    output logic [DW-1:0]        o_wdata,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int WW = NBYTES * DW;

    state_e        state_reg;
    logic [WW-1:0] shift_reg;
    logic [LW-1:0] cnt_reg;
    logic          err_reg;

    logic          hold_valid;
    logic [WW-1:0] hold_data;
    logic [LW-1:0] hold_nbytes;

    logic          accept;
    logic          legal;
    logic          last_byte;
    logic          direct_load;
    logic          hold_load;
    logic          hold_clear;
    logic [LW-1:0] load_len;
    logic [WW-1:0] load_src;
    logic [WW-1:0] load_word;
    logic [WW-1:0] step_word;

    assign legal     = (i_nbytes != '0) && (i_nbytes <= LW'(NBYTES));
    assign accept    = i_valid && o_ready;
    assign o_winc    = (state_reg == SEND) && !i_wfull;
    assign last_byte = o_winc && (cnt_reg == LW'(1));

    // A new word bypasses the hold register whenever the shifter is free at the next edge
    assign direct_load = accept && legal && ((state_reg == IDLE) || last_byte);
    assign hold_load   = accept && legal && (state_reg == SEND) && !last_byte;
    assign hold_clear  = last_byte && hold_valid;

    always_comb begin
        load_len = hold_clear ? hold_nbytes : i_nbytes;
        load_src = hold_clear ? hold_data : i_data;
`ifdef PACKER_MSB_FIRST_EN
        load_word = load_src << (DW * (NBYTES - int'(load_len)));
        step_word = shift_reg << DW;
`else
        load_word = load_src;
        step_word = shift_reg >> DW;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= accept && !legal;
            case (state_reg)
                IDLE: begin
                    if (direct_load) begin
                        shift_reg <= load_word;
                        cnt_reg   <= load_len;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (last_byte && (hold_clear || direct_load)) begin
                        shift_reg <= load_word;
                        cnt_reg   <= load_len;
                    end else if (o_winc) begin
                        shift_reg <= step_word;
                        cnt_reg   <= cnt_reg - LW'(1);
                        if (last_byte) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    packer_hold_reg #(
        .DW     (DW),
        .NBYTES (NBYTES),
        .LW     (LW)
    ) u_hold (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (hold_load),
        .i_clear  (hold_clear),
        .i_data   (i_data),
        .i_nbytes (i_nbytes),
        .o_valid  (hold_valid),
        .o_data   (hold_data),
        .o_nbytes (hold_nbytes),
        .o_ready  (o_ready)
    );

`ifdef PACKER_MSB_FIRST_EN
    assign o_wdata = shift_reg[WW-1 -: DW];
`else
    assign o_wdata = shift_reg[DW-1:0];
`endif

    assign o_busy = (state_reg == SEND) || hold_valid;
    assign o_err  = err_reg;

endmodule
